seq_detector: RTL and testbench
===============================

SEQ_DETECTOR -- requirements
Module: seq_detector

Interface
REQ-001 The module SHALL have parameter STATE_WIDTH, default 4: width of the state register in bits; legal range 3..8.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit: reset, synchronous and active-high (asserted = 1), despite the suffix.
REQ-004 The module SHALL have port seq_in, input, 1 bit: serial data, one bit sampled per rising clk edge.
REQ-005 The module SHALL have port out, output, 1 bit: detection flag, high for the cycle following each completed "1011" pattern.

Function
REQ-006 The block SHALL be a Moore FSM detecting serial pattern 1-0-1-1 (first bit received first), with overlap allowed.
REQ-007 The FSM SHALL have exactly five states, binary-encoded in STATE_WIDTH bits: IDLE=0, S1=1, S10=2, S101=3, S1011=4.
REQ-008 Transitions on each rising clk edge SHALL be: IDLE: 1->S1, 0->IDLE.
REQ-009 S1: 1->S1, 0->S10.
REQ-010 S10: 1->S101, 0->IDLE.
REQ-011 S101: 1->S1011, 0->S10.
REQ-012 S1011: 1->S1, 0->S10 (overlap: trailing "1" and "10" are reused).
REQ-013 The FSM SHALL treat any seq_in value other than 1 (0, X, Z) as 0.
REQ-014 Any unreachable state encoding SHALL transition to IDLE on the next edge.
REQ-015 out SHALL be 1 exactly while the state register equals S1011, otherwise 0, decoded from registered state only (no combinational path from seq_in).
REQ-016 Latency: out SHALL rise at the same rising edge that samples the final '1' of the pattern and stay high for one clock period unless re-entered.
REQ-017 A pattern SHALL be detected only from bits sampled after reset deassertion; partial patterns spanning a reset SHALL NOT be detected.

Reset
REQ-018 While rst_n=1 at a rising clk edge, the state SHALL become IDLE and out SHALL be 0 from that edge on.
REQ-019 Reset SHALL take priority over seq_in in the same cycle.
REQ-020 Assertion mid-pattern, including while in S1011, SHALL discard all progress.
REQ-021 Before the first reset edge, the state and out values SHALL be don't-care.

Structure
REQ-022 State encodings IDLE..S1011 and the pattern constant 4'b1011 SHALL live in package seq_detector_pkg.
REQ-023 A sub-module is not natural: state register, next-state logic and output decode SHALL reside in seq_detector.
REQ-024 An elaboration-time check SHALL fail compilation when STATE_WIDTH < 3.

Verification
REQ-025 Reset, then seq_in = 1,0,1,0,1,1,0,1,1 one bit per cycle -> out=1 only in the cycles after the 6th and 9th sampled bits; two pulses in total.
REQ-026 seq_in = 1,0,1,1,0,1,1 -> out pulses after bits 4 and 7 (overlap check).
REQ-027 seq_in = 1,1,1,0,1,1 -> single pulse after bit 6; the leading 1s do not cause a false hit.
REQ-028 seq_in = 1,0,1 then rst_n=1 for one cycle, then 1 -> no pulse; state IDLE after the reset edge.
REQ-029 Hold rst_n=1 while seq_in toggles through 1011 -> out stays 0 throughout.
REQ-030 Leave seq_in X for 3 cycles after reset, then drive 1,0,1,1 -> out stays 0 during the X cycles, then one pulse after the final 1.

Source files
------------

// File: rtl/seq_detector_pkg.sv
// Shared encodings for the serial "1011" pattern detector.
// State values are the binary codes held in the detector's state register.
package seq_detector_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    S1    = 3'd1,
    S10   = 3'd2,
    S101  = 3'd3,
    S1011 = 3'd4
  } state_e;

  // First bit received is the MSB.
  localparam logic [3:0] PATTERN = 4'b1011;

endpackage

// File: rtl/seq_detector.sv
// Moore detector for the overlapping serial pattern 1-0-1-1.
// state | meaning
// IDLE  | no useful prefix seen
// S1    | last bit "1"
// S10   | last bits "10"
// S101  | last bits "101"
// S1011 | full pattern seen, out high
module seq_detector
  import seq_detector_pkg::*;
#(
  parameter int STATE_WIDTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic seq_in,
  output logic out
);

  if (STATE_WIDTH < 3) begin : g_width_too_small
    $error("seq_detector: STATE_WIDTH must be at least 3");
  end
  if (STATE_WIDTH > 8) begin : g_width_too_large
    $error("seq_detector: STATE_WIDTH must be at most 8");
  end

  localparam logic [STATE_WIDTH-1:0] ST_IDLE  = STATE_WIDTH'(IDLE);
  localparam logic [STATE_WIDTH-1:0] ST_S1    = STATE_WIDTH'(S1);
  localparam logic [STATE_WIDTH-1:0] ST_S10   = STATE_WIDTH'(S10);
  localparam logic [STATE_WIDTH-1:0] ST_S101  = STATE_WIDTH'(S101);
  localparam logic [STATE_WIDTH-1:0] ST_S1011 = STATE_WIDTH'(S1011);

  logic [STATE_WIDTH-1:0] state_q;
  logic [STATE_WIDTH-1:0] state_d;
  logic                   bit_one;

  // X or Z on seq_in falls into the else path and is treated as 0.
  always_comb begin
    bit_one = 1'b0;
    if (seq_in == 1'b1) begin
      bit_one = 1'b1;
    end
  end

  // rst_n is active-high despite its name.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE:  state_d = bit_one ? ST_S1    : ST_IDLE;
      ST_S1:    state_d = bit_one ? ST_S1    : ST_S10;
      ST_S10:   state_d = bit_one ? ST_S101  : ST_IDLE;
      ST_S101:  state_d = bit_one ? ST_S1011 : ST_S10;
      ST_S1011: state_d = bit_one ? ST_S1    : ST_S10;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign out = (state_q == ST_S1011);

endmodule

// File: tb/tb_seq_detector.sv
// Directed and random stimulus for seq_detector, checked against a
// sliding-window model of the last four bits sampled since reset.
module tb_seq_detector;
  import seq_detector_pkg::*;

  logic clk;
  logic rst_n;
  logic seq_in;
  logic out;

  int checks;
  int failures;

  // Reference model: bits sampled since the last reset edge.
  logic [3:0] win;
  int         nbits;
  logic       exp_out;

  seq_detector #(.STATE_WIDTH(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .seq_in (seq_in),
    .out    (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, expv);
    end
  endtask

  // Apply one cycle of inputs, advance the model, check out after the edge.
  task automatic step(input string tag, input logic rst, input logic b);
    rst_n  = rst;
    seq_in = b;
    @(posedge clk);
    #1;
    if (rst) begin
      win   = 4'b0000;
      nbits = 0;
    end else begin
      win   = {win[2:0], (b === 1'b1)};
      nbits = nbits + 1;
    end
    exp_out = (nbits >= 4) && (win == PATTERN);
    check(tag, out, exp_out);
  endtask

  task automatic drive_bits(input string tag, input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      step(tag, 1'b0, bits[i]);
    end
  endtask

  int pulses;

  initial begin
    checks   = 0;
    failures = 0;
    win      = 4'b0000;
    nbits    = 0;
    rst_n    = 1'b1;
    seq_in   = 1'b0;

    step("reset", 1'b1, 1'b0);
    checks++;
    assert (dut.state_q === 4'd0) else begin
      failures++;
      $error("FAIL reset_state observed=%0d expected=0", dut.state_q);
    end

    // 1,0,1,0,1,1,0,1,1: pulses after bits 6 and 9
    pulses = 0;
    for (int i = 8; i >= 0; i--) begin
      logic [8:0] v;
      v = 9'b101011011;
      step("seq_a", 1'b0, v[i]);
      if (out === 1'b1) pulses++;
    end
    checks++;
    assert (pulses == 2) else begin
      failures++;
      $error("FAIL seq_a_pulses observed=%0d expected=2", pulses);
    end

    step("rst_b", 1'b1, 1'b1);
    pulses = 0;
    for (int i = 6; i >= 0; i--) begin
      logic [6:0] v;
      v = 7'b1011011;
      step("overlap", 1'b0, v[i]);
      if (out === 1'b1) pulses++;
    end
    checks++;
    assert (pulses == 2) else begin
      failures++;
      $error("FAIL overlap_pulses observed=%0d expected=2", pulses);
    end

    step("rst_c", 1'b1, 1'b0);
    drive_bits("lead_ones", 16'b111011, 6);

    // Partial 101 then reset: must not complete across the reset.
    step("rst_d", 1'b1, 1'b0);
    drive_bits("pre_reset", 16'b101, 3);
    step("mid_reset", 1'b1, 1'b1);
    checks++;
    assert (dut.state_q === 4'd0) else begin
      failures++;
      $error("FAIL mid_reset_state observed=%0d expected=0", dut.state_q);
    end
    step("post_reset", 1'b0, 1'b1);
    drive_bits("post_reset_tail", 16'b011, 3);

    // Reset held while the pattern streams past, including in S1011.
    drive_bits("to_s1011", 16'b1011, 4);
    for (int i = 3; i >= 0; i--) begin
      logic [3:0] v;
      v = 4'b1011;
      step("held_reset", 1'b1, v[i]);
    end

    // X inputs after reset count as 0.
    for (int i = 0; i < 3; i++) step("x_input", 1'b0, 1'bx);
    drive_bits("after_x", 16'b1011, 4);

    // Random traffic with occasional resets and X bits.
    for (int i = 0; i < 400; i++) begin
      logic r;
      logic b;
      r = ($urandom_range(0, 24) == 0);
      b = ($urandom_range(0, 15) == 0) ? 1'bx : 1'($urandom_range(0, 1));
      step("random", r, b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
